// File: rtl/key_input_pkg.sv
// Shared types and helpers for the key input conditioner.
package key_input_pkg;

    localparam int unsigned KEY_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        PRESSED   = 2'd2,
        RELEASING = 2'd3
    } key_state_t;

    localparam logic [KEY_WIDTH_DEFAULT-1:0] KEY_NONE = '0;

    function automatic logic is_one_hot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

    function automatic logic is_multi_hot(input logic [31:0] v);
        return (v & (v - 32'd1)) != 32'd0;
    endfunction

endpackage

// File: rtl/key_input_if.sv
// Raw button pins in, conditioned key level / strobe / conflict flag out.
interface key_input_if #(
    parameter int unsigned KEY_WIDTH = 4
);
    logic [KEY_WIDTH-1:0] rawKey;
    logic [KEY_WIDTH-1:0] key;
    logic [KEY_WIDTH-1:0] keyPulse;
    logic                 keyConflict;

    modport master (output rawKey, input key, keyPulse, keyConflict);
    modport slave  (input rawKey, output key, keyPulse, keyConflict);
endinterface

// File: rtl/key_synchroniser.sv
// Two-flop synchroniser for the asynchronous button pins.
module key_synchroniser #(
    parameter int unsigned           KEY_WIDTH   = 4,
    parameter logic [KEY_WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [KEY_WIDTH-1:0] pins,
    output logic [KEY_WIDTH-1:0] synced
);
    logic [KEY_WIDTH-1:0] meta;

    always_ff @(posedge clock) begin
        if (!reset) begin
            meta   <= RESET_VALUE;
            synced <= RESET_VALUE;
        end else begin
            meta   <= pins;
            synced <= meta;
        end
    end
endmodule

// File: rtl/key_input_conditioner.sv
// Synchronise, debounce and arbitrate push-buttons into a single one-hot key level.
// Optional auto-repeat strobes while held: define KEY_REPEAT_EN.
module key_input_conditioner
    import key_input_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ             = 50000000,
    parameter int unsigned DEBOUNCE_MS            = 20,
    parameter int unsigned DEBOUNCE_CYCLES        = CLOCK_FREQ / 1000 * DEBOUNCE_MS,
    parameter int unsigned DEBOUNCE_COUNTER_WIDTH = $clog2(DEBOUNCE_CYCLES + 1),
    parameter int unsigned KEY_WIDTH              = 4,
    parameter int unsigned RAW_ACTIVE_LOW         = 1,
    parameter int unsigned REPEAT_DELAY_CYCLES    = 25000000,
    parameter int unsigned REPEAT_PERIOD_CYCLES   = 10000000
) (
    input  logic        clock,
    input  logic        reset,
    key_input_if.slave  bus
);
    localparam logic [KEY_WIDTH-1:0] NONE     = KEY_WIDTH'(KEY_NONE);
    localparam logic [KEY_WIDTH-1:0] RELEASED = (RAW_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [DEBOUNCE_COUNTER_WIDTH-1:0] COUNT_LAST =
        DEBOUNCE_COUNTER_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEBOUNCE_COUNTER_WIDTH-1:0] COUNT_ONE = DEBOUNCE_COUNTER_WIDTH'(1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY_CYCLES == 0 || REPEAT_PERIOD_CYCLES == 0) begin : g_param_check
        $error("key_input_conditioner: invalid timing parameters");
    end

    logic [KEY_WIDTH-1:0] synced;
    logic [KEY_WIDTH-1:0] sample;
    logic [KEY_WIDTH-1:0] candidate;
    logic [KEY_WIDTH-1:0] key_level;
    logic [KEY_WIDTH-1:0] key_pulse;
    logic                 conflict;
    logic [DEBOUNCE_COUNTER_WIDTH-1:0] count;
    key_state_t           state;

    key_synchroniser #(
        .KEY_WIDTH   (KEY_WIDTH),
        .RESET_VALUE (RELEASED)
    ) u_sync (
        .clock  (clock),
        .reset  (reset),
        .pins   (bus.rawKey),
        .synced (synced)
    );

    assign sample = (RAW_ACTIVE_LOW != 0) ? ~synced : synced;

`ifdef KEY_REPEAT_EN
    localparam int unsigned REPEAT_SPAN  = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                                           REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int unsigned REPEAT_WIDTH = $clog2(REPEAT_SPAN + 1);

    logic [REPEAT_WIDTH-1:0] repeat_count;
    logic [REPEAT_WIDTH-1:0] repeat_last;
    logic                    repeating;

    // First strobe after the initial delay, then at the repeat period.
    assign repeat_last = repeating ? REPEAT_WIDTH'(REPEAT_PERIOD_CYCLES - 1)
                                   : REPEAT_WIDTH'(REPEAT_DELAY_CYCLES - 1);
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            candidate <= NONE;
            count     <= '0;
            key_level <= NONE;
            key_pulse <= NONE;
            conflict  <= 1'b0;
`ifdef KEY_REPEAT_EN
            repeat_count <= '0;
            repeating    <= 1'b0;
`endif
        end else begin
            key_pulse <= NONE;
            conflict  <= is_multi_hot(32'(sample));
            case (state)
                IDLE: begin
                    key_level <= NONE;
                    count     <= '0;
                    if (is_one_hot(32'(sample))) begin
                        candidate <= sample;
                        state     <= ARMING;
                    end
                end
                ARMING: begin
                    if (sample != candidate) begin
                        count <= '0;
                        state <= IDLE;
                    end else if (count == COUNT_LAST) begin
                        key_level <= candidate;
                        key_pulse <= candidate;
                        state     <= PRESSED;
`ifdef KEY_REPEAT_EN
                        repeat_count <= '0;
                        repeating    <= 1'b0;
`endif
                    end else begin
                        count <= count + COUNT_ONE;
                    end
                end
                PRESSED: begin
                    if (sample != candidate) begin
                        count <= '0;
                        state <= RELEASING;
                    end
`ifdef KEY_REPEAT_EN
                    else if (repeat_count == repeat_last) begin
                        key_pulse    <= candidate;
                        repeat_count <= '0;
                        repeating    <= 1'b1;
                    end else begin
                        repeat_count <= repeat_count + REPEAT_WIDTH'(1);
                    end
`endif
                end
                RELEASING: begin
                    // A second key or a bounce restarts the release window; key stays held.
                    if (sample == candidate) begin
                        state <= PRESSED;
                    end else if (sample != NONE) begin
                        count <= '0;
                    end else if (count == COUNT_LAST) begin
                        key_level <= NONE;
                        count     <= '0;
                        state     <= IDLE;
                    end else begin
                        count <= count + COUNT_ONE;
                    end
                end
                default: begin
                    key_level <= NONE;
                    count     <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.key         = key_level;
    assign bus.keyPulse    = key_pulse;
    assign bus.keyConflict = conflict;
endmodule

// File: tb/tb_key_input_conditioner.sv
// Directed bench for key_input_conditioner with DEBOUNCE_CYCLES=4, active-low pins.
module tb_key_input_conditioner;
    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   pulse_count = 0;
    int   multi_hot_seen = 0;

    key_input_if #(.KEY_WIDTH(4)) bus ();

    key_input_conditioner #(
        .DEBOUNCE_CYCLES      (4),
        .KEY_WIDTH            (4),
        .RAW_ACTIVE_LOW       (1),
        .REPEAT_DELAY_CYCLES  (20),
        .REPEAT_PERIOD_CYCLES (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            if (bus.keyPulse != 4'b0000) pulse_count++;
            if ((bus.key & (bus.key - 4'd1)) != 4'd0) multi_hot_seen++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.rawKey = 4'b1111;
        tick(2);
        checks++; if (bus.key !== 4'b0000) begin errors++; $display("FAIL reset_key: got %b expected %b", bus.key, 4'b0000); end
        checks++; if (bus.keyPulse !== 4'b0000) begin errors++; $display("FAIL reset_pulse: got %b expected %b", bus.keyPulse, 4'b0000); end
        checks++; if (bus.keyConflict !== 1'b0) begin errors++; $display("FAIL reset_conflict: got %b expected %b", bus.keyConflict, 1'b0); end
        reset = 1'b1;
        tick(3);
        checks++; if (bus.key !== 4'b0000) begin errors++; $display("FAIL idle_key: got %b expected %b", bus.key, 4'b0000); end
    endtask

    task automatic test_clean_press();
        bus.rawKey = 4'b1101;
        pulse_count = 0;
        tick(6);
        checks++; if (bus.key !== 4'b0000) begin errors++; $display("FAIL press_early: got %b expected %b", bus.key, 4'b0000); end
        tick(1);
        checks++; if (bus.key !== 4'b0010) begin errors++; $display("FAIL press_key: got %b expected %b", bus.key, 4'b0010); end
        checks++; if (bus.keyPulse !== 4'b0010) begin errors++; $display("FAIL press_pulse: got %b expected %b", bus.keyPulse, 4'b0010); end
        tick(1);
        checks++; if (bus.keyPulse !== 4'b0000) begin errors++; $display("FAIL press_pulse_end: got %b expected %b", bus.keyPulse, 4'b0000); end
        tick(5);
        checks++; if (bus.key !== 4'b0010) begin errors++; $display("FAIL press_hold: got %b expected %b", bus.key, 4'b0010); end
        bus.rawKey = 4'b1111;
        tick(6);
        checks++; if (bus.key !== 4'b0010) begin errors++; $display("FAIL release_early: got %b expected %b", bus.key, 4'b0010); end
        tick(1);
        checks++; if (bus.key !== 4'b0000) begin errors++; $display("FAIL release_key: got %b expected %b", bus.key, 4'b0000); end
        checks++; if (pulse_count !== 1) begin errors++; $display("FAIL press_pulse_count: got %0d expected %0d", pulse_count, 1); end
        tick(3);
    endtask

    task automatic test_bounce();
        int key_seen;
        key_seen = 0;
        pulse_count = 0;
        for (int i = 0; i < 5; i++) begin
            bus.rawKey = 4'b1110;
            tick(1); if (bus.key != 4'b0000) key_seen++;
            tick(1); if (bus.key != 4'b0000) key_seen++;
            bus.rawKey = 4'b1111;
            tick(1); if (bus.key != 4'b0000) key_seen++;
            tick(1); if (bus.key != 4'b0000) key_seen++;
        end
        checks++; if (key_seen !== 0) begin errors++; $display("FAIL bounce_no_key: got %0d expected %0d", key_seen, 0); end
        bus.rawKey = 4'b1110;
        tick(6);
        checks++; if (bus.key !== 4'b0000) begin errors++; $display("FAIL bounce_early: got %b expected %b", bus.key, 4'b0000); end
        tick(1);
        checks++; if (bus.key !== 4'b0001) begin errors++; $display("FAIL bounce_key: got %b expected %b", bus.key, 4'b0001); end
        tick(10);
        checks++; if (pulse_count !== 1) begin errors++; $display("FAIL bounce_pulses: got %0d expected %0d", pulse_count, 1); end
        bus.rawKey = 4'b1111;
        tick(7);
        checks++; if (bus.key !== 4'b0000) begin errors++; $display("FAIL bounce_release: got %b expected %b", bus.key, 4'b0000); end
        tick(3);
    endtask

    task automatic test_two_keys();
        bus.rawKey = 4'b1100;
        tick(2);
        checks++; if (bus.keyConflict !== 1'b0) begin errors++; $display("FAIL conflict_early: got %b expected %b", bus.keyConflict, 1'b0); end
        tick(1);
        checks++; if (bus.keyConflict !== 1'b1) begin errors++; $display("FAIL conflict_set: got %b expected %b", bus.keyConflict, 1'b1); end
        tick(8);
        checks++; if (bus.key !== 4'b0000) begin errors++; $display("FAIL conflict_no_key: got %b expected %b", bus.key, 4'b0000); end
        bus.rawKey = 4'b1101;
        tick(6);
        checks++; if (bus.key !== 4'b0000) begin errors++; $display("FAIL single_early: got %b expected %b", bus.key, 4'b0000); end
        checks++; if (bus.keyConflict !== 1'b0) begin errors++; $display("FAIL conflict_clear: got %b expected %b", bus.keyConflict, 1'b0); end
        tick(1);
        checks++; if (bus.key !== 4'b0010) begin errors++; $display("FAIL single_key: got %b expected %b", bus.key, 4'b0010); end
        bus.rawKey = 4'b1111;
        tick(7);
        checks++; if (bus.key !== 4'b0000) begin errors++; $display("FAIL single_release: got %b expected %b", bus.key, 4'b0000); end
        tick(3);
    endtask

    task automatic test_second_key();
        bus.rawKey = 4'b1110;
        tick(7);
        checks++; if (bus.key !== 4'b0001) begin errors++; $display("FAIL hold_key: got %b expected %b", bus.key, 4'b0001); end
        pulse_count = 0;
        bus.rawKey = 4'b1100;
        tick(10);
        checks++; if (bus.key !== 4'b0001) begin errors++; $display("FAIL second_key_hold: got %b expected %b", bus.key, 4'b0001); end
        checks++; if (pulse_count !== 0) begin errors++; $display("FAIL second_key_pulses: got %0d expected %0d", pulse_count, 0); end
        checks++; if (bus.keyConflict !== 1'b1) begin errors++; $display("FAIL second_key_conflict: got %b expected %b", bus.keyConflict, 1'b1); end
        bus.rawKey = 4'b1111;
        tick(5);
        checks++; if (bus.key !== 4'b0001) begin errors++; $display("FAIL second_release_early: got %b expected %b", bus.key, 4'b0001); end
        tick(2);
        checks++; if (bus.key !== 4'b0000) begin errors++; $display("FAIL second_release: got %b expected %b", bus.key, 4'b0000); end
        tick(2);
        bus.rawKey = 4'b1011;
        tick(7);
        checks++; if (bus.key !== 4'b0100) begin errors++; $display("FAIL new_press_key: got %b expected %b", bus.key, 4'b0100); end
        checks++; if (bus.keyPulse !== 4'b0100) begin errors++; $display("FAIL new_press_pulse: got %b expected %b", bus.keyPulse, 4'b0100); end
        bus.rawKey = 4'b1111;
        tick(10);
    endtask

    task automatic test_reset_mid_press();
        bus.rawKey = 4'b0111;
        tick(7);
        checks++; if (bus.key !== 4'b1000) begin errors++; $display("FAIL mid_key: got %b expected %b", bus.key, 4'b1000); end
        reset = 1'b0;
        tick(1);
        checks++; if (bus.key !== 4'b0000) begin errors++; $display("FAIL mid_reset_key: got %b expected %b", bus.key, 4'b0000); end
        reset = 1'b1;
        pulse_count = 0;
        tick(6);
        checks++; if (bus.key !== 4'b0000) begin errors++; $display("FAIL requalify_early: got %b expected %b", bus.key, 4'b0000); end
        checks++; if (pulse_count !== 0) begin errors++; $display("FAIL requalify_no_pulse: got %0d expected %0d", pulse_count, 0); end
        tick(1);
        checks++; if (bus.key !== 4'b1000) begin errors++; $display("FAIL requalify_key: got %b expected %b", bus.key, 4'b1000); end
        checks++; if (bus.keyPulse !== 4'b1000) begin errors++; $display("FAIL requalify_pulse: got %b expected %b", bus.keyPulse, 4'b1000); end
        bus.rawKey = 4'b1111;
        tick(10);
    endtask

    task automatic test_hold_repeat();
        logic       repeat_mode;
        logic [3:0] want;
`ifdef KEY_REPEAT_EN
        repeat_mode = 1'b1;
`else
        repeat_mode = 1'b0;
`endif
        bus.rawKey = 4'b1110;
        tick(7);
        checks++; if (bus.keyPulse !== 4'b0001) begin errors++; $display("FAIL hold_first_pulse: got %b expected %b", bus.keyPulse, 4'b0001); end
        for (int k = 1; k <= 50; k++) begin
            tick(1);
            want = (repeat_mode && (k == 20 || k == 28 || k == 36 || k == 44)) ? 4'b0001 : 4'b0000;
            checks++; if (bus.keyPulse !== want) begin errors++; $display("FAIL hold_pulse_%0d: got %b expected %b", k, bus.keyPulse, want); end
        end
        checks++; if (bus.key !== 4'b0001) begin errors++; $display("FAIL hold_level: got %b expected %b", bus.key, 4'b0001); end
        bus.rawKey = 4'b1111;
        tick(7);
        checks++; if (bus.key !== 4'b0000) begin errors++; $display("FAIL hold_release: got %b expected %b", bus.key, 4'b0000); end
    endtask

    initial begin
        reset = 1'b0;
        bus.rawKey = 4'b1111;
        test_reset();
        test_clean_press();
        test_bounce();
        test_two_keys();
        test_second_key();
        test_reset_mid_press();
        test_hold_repeat();
        checks++; if (multi_hot_seen !== 0) begin errors++; $display("FAIL key_one_hot: got %0d expected %0d", multi_hot_seen, 0); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
